tdoa_capture_controller: RTL

// Sits downstream of NUM_CH PCM peak detectors, one per microphone channel, all on pcm_clk.

---
 rtl/tdoa_capture_if.sv | 46 ++++
 rtl/tdoa_capture_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tdoa_capture_if.sv
// Capture-controller bus: detector inputs, arm/ack handshake and the result.
//   master : the side that arms, acks and feeds detector data (localiser / bench)
//   slave  : tdoa_capture_controller
// Signals
//   arm, ack                 start capture / accept result
//   triggered[NUM_CH]        per-channel detector triggered flags
//   triggered_time[32*NUM_CH] per-channel peak times, ch i at [32i+31:32i]
//   sample_counter[32]       free-running sample count
//   det_reset, busy          detector sync reset, controller not idle
//   result_valid             result fields valid, held until ack
//   ch_mask, partial         channels present at snapshot, not-all-present flag
//   ref_ch, ref_time         earliest channel and its peak time
//   delta_bus, sat           per-channel arrival deltas and saturation flags
interface tdoa_capture_if #(
    parameter int NUM_CH  = 4,
    parameter int DELTA_W = 16
);
    localparam int REF_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                        arm;
    logic                        ack;
    logic [NUM_CH-1:0]           triggered;
    logic [32*NUM_CH-1:0]        triggered_time;
    logic [31:0]                 sample_counter;
    logic                        det_reset;
    logic                        busy;
    logic                        result_valid;
    logic [NUM_CH-1:0]           ch_mask;
    logic                        partial;
    logic [REF_W-1:0]            ref_ch;
    logic [31:0]                 ref_time;
    logic [DELTA_W*NUM_CH-1:0]   delta_bus;
    logic [NUM_CH-1:0]           sat;

    modport master (
        output arm, ack, triggered, triggered_time, sample_counter,
        input  det_reset, busy, result_valid, ch_mask, partial,
               ref_ch, ref_time, delta_bus, sat
    );

    modport slave (
        input  arm, ack, triggered, triggered_time, sample_counter,
        output det_reset, busy, result_valid, ch_mask, partial,
               ref_ch, ref_time, delta_bus, sat
    );
endinterface

// File: rtl/tdoa_capture_controller.sv
// TDOA capture controller.
// Arms NUM_CH peak detectors, waits for the first trigger, lets peak times settle
// for CAPTURE_WINDOW cycles, snapshots all channels, then finds the earliest
// channel (one channel per cycle) and computes saturated per-channel deltas
// (one channel per cycle). The result is held with result_valid until ack,
// after which the detectors are held in reset for HOLDOFF cycles.
// Ports
//   pcm_clk  : sample clock
//   reset_n  : asynchronous active-low reset
//   bus      : tdoa_capture_if slave modport (handshake, detector data, result)
module tdoa_capture_controller #(
    parameter int NUM_CH         = 4,
    parameter int CAPTURE_WINDOW = 2400,
    parameter int HOLDOFF        = 4800,
    parameter int DELTA_W        = 16
) (
    input  logic          pcm_clk,
    input  logic          reset_n,
    tdoa_capture_if.slave bus
);
    localparam int REF_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int M1      = (CAPTURE_WINDOW > HOLDOFF) ? CAPTURE_WINDOW : HOLDOFF;
    localparam int CNT_MAX = (M1 > NUM_CH) ? M1 : NUM_CH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(CAPTURE_WINDOW - 1);
    localparam logic [CNT_W-1:0] CH_LAST   = CNT_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
    // Largest representable delta; anything above saturates to all-ones.
    localparam logic [31:0] DMAX = (DELTA_W >= 32) ? 32'hFFFF_FFFF
                                                   : 32'((64'd1 << DELTA_W) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ARMED, S_WINDOW, S_SCAN, S_DELTA, S_RESULT, S_HOLDOFF
    } state_t;

    state_t                          r_state, w_state_nxt;
    logic [CNT_W-1:0]                r_cnt;
    logic [31:0]                     r_arm_time;
    logic [NUM_CH-1:0]               r_mask;
    logic                            r_partial;
    logic [NUM_CH-1:0][31:0]         r_time;
    logic [NUM_CH-1:0][31:0]         r_off;
    logic [31:0]                     r_min_off;
    logic                            r_found;
    logic [REF_W-1:0]                r_ref_ch;
    logic [31:0]                     r_ref_time;
    logic [NUM_CH-1:0][DELTA_W-1:0]  r_delta;
    logic [NUM_CH-1:0]               r_sat;
    logic                            r_result_valid;

    logic                            w_latch_arm, w_snap, w_scan, w_delta, w_done, w_take_ack;
    logic                            w_counting;
    logic [REF_W-1:0]                w_idx;
    logic [31:0]                     w_off;
    logic [31:0]                     w_d32;
    logic                            w_dsat;
    logic [DELTA_W-1:0]              w_dval;

    // ---------------- FSM ----------------
    always_ff @(posedge pcm_clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch_arm = 1'b0;
        w_snap      = 1'b0;
        w_scan      = 1'b0;
        w_delta     = 1'b0;
        w_done      = 1'b0;
        w_take_ack  = 1'b0;
        case (r_state)
            S_IDLE:    if (bus.arm) w_state_nxt = S_CLEAR;
            S_CLEAR:   if (r_cnt == CLR_LAST) begin
                           w_latch_arm = 1'b1;
                           w_state_nxt = S_ARMED;
                       end
            S_ARMED:   if (|bus.triggered) w_state_nxt = S_WINDOW;
            S_WINDOW:  if (r_cnt == WIN_LAST) begin
                           w_snap      = 1'b1;
                           w_state_nxt = S_SCAN;
                       end
            S_SCAN:    begin
                           w_scan = 1'b1;
                           if (r_cnt == CH_LAST) w_state_nxt = S_DELTA;
                       end
            S_DELTA:   begin
                           w_delta = 1'b1;
                           if (r_cnt == CH_LAST) begin
                               w_done      = 1'b1;
                               w_state_nxt = S_RESULT;
                           end
                       end
            // arm is not looked at here, so arm+ack together just takes the ack.
            S_RESULT:  if (bus.ack) begin
                           w_take_ack  = 1'b1;
                           w_state_nxt = S_HOLDOFF;
                       end
            S_HOLDOFF: if (r_cnt == HOLD_LAST) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign w_counting = (r_state == S_CLEAR)  || (r_state == S_WINDOW) ||
                        (r_state == S_SCAN)   || (r_state == S_DELTA)  ||
                        (r_state == S_HOLDOFF);

    // Counter restarts from 0 on every state change.
    always_ff @(posedge pcm_clk or negedge reset_n) begin
        if (!reset_n)                    r_cnt <= '0;
        else if (w_state_nxt != r_state) r_cnt <= '0;
        else if (w_counting)             r_cnt <= r_cnt + CNT_W'(1);
    end

    // ---------------- datapath ----------------
    assign w_idx = r_cnt[REF_W-1:0];
    // Offsets relative to arm_time make the comparison wrap-safe.
    assign w_off = r_time[w_idx] - r_arm_time;
    assign w_d32 = r_off[w_idx] - r_min_off;
    assign w_dsat = r_mask[w_idx] && (w_d32 > DMAX);
    assign w_dval = !r_mask[w_idx] ? '0 : (w_dsat ? '1 : DELTA_W'(w_d32));

    always_ff @(posedge pcm_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm_time     <= '0;
            r_mask         <= '0;
            r_partial      <= 1'b0;
            r_time         <= '0;
            r_off          <= '0;
            r_min_off      <= '0;
            r_found        <= 1'b0;
            r_ref_ch       <= '0;
            r_ref_time     <= '0;
            r_delta        <= '0;
            r_sat          <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (w_latch_arm) r_arm_time <= bus.sample_counter;

            // Old result is kept until here; clear it so masked channels read 0.
            if (w_snap) begin
                r_mask     <= bus.triggered;
                r_partial  <= ~&bus.triggered;
                r_time     <= bus.triggered_time;
                r_found    <= 1'b0;
                r_min_off  <= '0;
                r_ref_ch   <= '0;
                r_ref_time <= '0;
                r_delta    <= '0;
                r_sat      <= '0;
            end

            // Strict '<' keeps the lowest index on ties.
            if (w_scan) begin
                r_off[w_idx] <= w_off;
                if (r_mask[w_idx] && (!r_found || (w_off < r_min_off))) begin
                    r_found    <= 1'b1;
                    r_min_off  <= w_off;
                    r_ref_ch   <= w_idx;
                    r_ref_time <= r_time[w_idx];
                end
            end

            if (w_delta) begin
                r_delta[w_idx] <= w_dval;
                r_sat[w_idx]   <= w_dsat;
            end

            if (w_done)          r_result_valid <= 1'b1;
            else if (w_take_ack) r_result_valid <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    assign bus.det_reset    = (r_state == S_IDLE) || (r_state == S_CLEAR) ||
                              (r_state == S_HOLDOFF);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.result_valid = r_result_valid;
    assign bus.ch_mask      = r_mask;
    assign bus.partial      = r_partial;
    assign bus.ref_ch       = r_ref_ch;
    assign bus.ref_time     = r_ref_time;
    assign bus.delta_bus    = r_delta;
    assign bus.sat          = r_sat;
endmodule
